pad_cmd_encoder: RTL and testbench

- Sits directly downstream of the gamepad debouncer and consumes its six debounced, active-high button levels.
- Converts button presses into single-word command tokens for the game-logic FSM. A new press is a rising edge of the level. A held direction button also generates auto-repeat events.
- Simultaneous presses are arbitrated by fixed priority.
- Commands are delivered over a valid/ready handshake, so the consumer may stall without losing events.

---
 rtl/pad_cmd_encoder.sv | 144 ++++++++++++++
 tb/tb_pad_cmd_encoder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_cmd_encoder.sv
// Gamepad command encoder: edge/auto-repeat events into a priority-arbitrated
// valid/ready command stream. Auto-repeat is built only with PAD_AUTOREPEAT_EN.
module pad_cmd_encoder #(
  parameter int CNT_W         = 25,
  parameter int REPEAT_DELAY  = 20000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_in,
  input  logic       down_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       a_in,
  input  logic       c_in,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic       repeat_active,
  output logic       drop_flag
);

  logic [5:0] btn;
  logic [5:0] prev;
  logic [5:0] pending;
  logic [5:0] edge_ev;
  logic [5:0] rep_ev;
  logic [5:0] low;
  logic [5:0] issue;
  logic       slot_free;
  logic [2:0] low_code;

  assign btn       = {c_in, a_in, right_in, left_in, down_in, up_in};
  assign edge_ev   = btn & ~prev;
  assign slot_free = ~cmd_valid | cmd_ready;
  assign low       = pending & (~pending + 6'd1);
  assign issue     = slot_free ? low : 6'd0;

  always_comb begin
    low_code = 3'd0;
    unique case (1'b1)
      low[0]:  low_code = 3'd1;
      low[1]:  low_code = 3'd2;
      low[2]:  low_code = 3'd3;
      low[3]:  low_code = 3'd4;
      low[4]:  low_code = 3'd5;
      low[5]:  low_code = 3'd6;
      default: low_code = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= 6'b111111;
      pending   <= 6'd0;
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      drop_flag <= 1'b0;
    end else begin
      prev    <= btn;
      pending <= (pending & ~issue) | edge_ev | rep_ev;
      // an issued bit frees its slot, so only un-issued bits coalesce
      if (|(edge_ev & pending & ~issue))
        drop_flag <= 1'b1;
      if (slot_free) begin
        cmd_valid <= |pending;
        cmd_code  <= low_code;
      end
    end
  end

`ifdef PAD_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, PERIOD} rpt_state_t;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  rpt_state_t       state;
  rpt_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       owner;
  logic [3:0]       owner_q;
  logic             fire;

  assign owner = btn[3:0] & (~btn[3:0] + 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner_q <= 4'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      owner_q <= owner;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    if (owner == 4'd0) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE || owner != owner_q) begin
      state_n = DELAY;
      cnt_n   = '0;
    end else begin
      unique case (state)
        DELAY: begin
          if (cnt == DLY_LAST) begin
            fire    = 1'b1;
            cnt_n   = '0;
            state_n = PERIOD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PERIOD: begin
          if (cnt == PER_LAST) begin
            fire  = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign rep_ev        = fire ? {2'b00, owner} : 6'd0;
  assign repeat_active = (state == PERIOD);
`else
  assign rep_ev        = 6'd0;
  assign repeat_active = 1'b0;
`endif

endmodule

// File: tb/tb_pad_cmd_encoder.sv
// Self-checking bench for pad_cmd_encoder: scoreboard of accepted commands
// (cycle, code) against expectations pushed as stimulus is driven.
module tb_pad_cmd_encoder;

  typedef struct packed {
    int         cyc;
    logic [2:0] code;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 0, dn = 0, lf = 0, rt = 0, a = 0, c = 0;
  logic       ready = 1'b0;
  logic       valid;
  logic [2:0] code;
  logic       ract;
  logic       drop;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  pad_cmd_encoder #(
    .CNT_W(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .up_in(up),
    .down_in(dn),
    .left_in(lf),
    .right_in(rt),
    .a_in(a),
    .c_in(c),
    .cmd_valid(valid),
    .cmd_code(code),
    .cmd_ready(ready),
    .repeat_active(ract),
    .drop_flag(drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (valid && ready)
      obs_q.push_back(ev_t'{cyc: cyc, code: code});

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    exp_q.delete();
    obs_q.delete();
    ready = 1'b1;
    rt = 1'b1;
    rst = 1'b1;
    step(2);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", valid);
    end
    n_chk++;
    if (code !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_code: got %0d want 0", code);
    end
    n_chk++;
    if (ract !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ract: got %b want 0", ract);
    end
    n_chk++;
    if (drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: got %b want 0", drop);
    end
    step(1);
    rst = 1'b0;
    step(5);
    rt = 1'b0;
    step(1);
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_thru_reset: got %0d cmds want 0", obs_q.size());
    end
  endtask

  task automatic test_edge;
    int m;
    exp_q.delete();
    obs_q.delete();
    step(1);
    m = cyc;
    rt = 1'b1;
    exp_q.push_back(ev_t'{cyc: m + 2, code: 3'd4});
    step(2);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b1 || code !== 3'd4) begin
      n_fail++;
      $display("FAIL edge_latency: got v=%b c=%0d want v=1 c=4", valid, code);
    end
    step(1);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_one_cycle: got v=%b want 0", valid);
    end
    rt = 1'b0;
    step(3);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL edge_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i])
      if (i < obs_q.size()) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL edge_cmd[%0d]: got cyc %0d code %0d want cyc %0d code %0d",
                   i, obs_q[i].cyc, obs_q[i].code, exp_q[i].cyc, exp_q[i].code);
        end
      end
  endtask

  task automatic test_simul;
    int m;
    exp_q.delete();
    obs_q.delete();
    m = cyc;
    up = 1'b1;
    a = 1'b1;
    c = 1'b1;
    exp_q.push_back(ev_t'{cyc: m + 2, code: 3'd1});
    exp_q.push_back(ev_t'{cyc: m + 3, code: 3'd5});
    exp_q.push_back(ev_t'{cyc: m + 4, code: 3'd6});
    step(1);
    up = 1'b0;
    a = 1'b0;
    c = 1'b0;
    step(4);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b0 || code !== 3'd0) begin
      n_fail++;
      $display("FAIL simul_idle: got v=%b c=%0d want v=0 c=0", valid, code);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL simul_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i])
      if (i < obs_q.size()) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL simul_cmd[%0d]: got cyc %0d code %0d want cyc %0d code %0d",
                   i, obs_q[i].cyc, obs_q[i].code, exp_q[i].cyc, exp_q[i].code);
        end
      end
  endtask

  task automatic test_stall;
    int m;
    exp_q.delete();
    obs_q.delete();
    step(1);
    m = cyc;
    ready = 1'b0;
    lf = 1'b1;
    exp_q.push_back(ev_t'{cyc: m + 11, code: 3'd3});
    exp_q.push_back(ev_t'{cyc: m + 12, code: 3'd2});
    for (int t = 1; t <= 12; t++) begin
      step(1);
      lf = 1'b0;
      dn = (t == 1 || t == 2 || t == 5 || t == 6);
      ready = (t >= 11);
      @(negedge clk);
      if (t >= 2 && t <= 11) begin
        n_chk++;
        if (valid !== 1'b1 || code !== 3'd3) begin
          n_fail++;
          $display("FAIL stall_hold t=%0d: got v=%b c=%0d want v=1 c=3", t, valid, code);
        end
      end
      if (t == 5) begin
        n_chk++;
        if (drop !== 1'b0) begin
          n_fail++;
          $display("FAIL drop_early: got %b want 0", drop);
        end
      end
      if (t == 7) begin
        n_chk++;
        if (drop !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_set: got %b want 1", drop);
        end
      end
      if (t == 12) begin
        n_chk++;
        if (valid !== 1'b1 || code !== 3'd2) begin
          n_fail++;
          $display("FAIL stall_next: got v=%b c=%0d want v=1 c=2", valid, code);
        end
      end
    end
    step(1);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_coalesce: got v=%b c=%0d want v=0", valid, code);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i])
      if (i < obs_q.size()) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stall_cmd[%0d]: got cyc %0d code %0d want cyc %0d code %0d",
                   i, obs_q[i].cyc, obs_q[i].code, exp_q[i].cyc, exp_q[i].code);
        end
      end
  endtask

  task automatic test_repeat;
    int   m;
    logic exp_r;
    step(1);
    do_reset();
    exp_q.delete();
    obs_q.delete();
    n_chk++;
    if (drop !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_cleared: got %b want 0", drop);
    end
    ready = 1'b1;
    m = cyc;
    up = 1'b1;
    exp_q.push_back(ev_t'{cyc: m + 2, code: 3'd1});
`ifdef PAD_AUTOREPEAT_EN
    exp_q.push_back(ev_t'{cyc: m + 10, code: 3'd1});
    exp_q.push_back(ev_t'{cyc: m + 14, code: 3'd1});
    exp_q.push_back(ev_t'{cyc: m + 18, code: 3'd1});
    exp_q.push_back(ev_t'{cyc: m + 22, code: 3'd1});
`endif
    for (int t = 1; t <= 26; t++) begin
      step(1);
      up = (t <= 20);
      @(negedge clk);
`ifdef PAD_AUTOREPEAT_EN
      exp_r = (t >= 9 && t <= 21);
`else
      exp_r = 1'b0;
`endif
      n_chk++;
      if (ract !== exp_r) begin
        n_fail++;
        $display("FAIL repeat_active t=%0d: got %b want %b", t, ract, exp_r);
      end
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i])
      if (i < obs_q.size()) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL repeat_cmd[%0d]: got cyc %0d code %0d want cyc %0d code %0d",
                   i, obs_q[i].cyc, obs_q[i].code, exp_q[i].cyc, exp_q[i].code);
        end
      end
  endtask

  task automatic test_owner;
    int m;
    step(1);
    do_reset();
    exp_q.delete();
    obs_q.delete();
    ready = 1'b1;
    m = cyc;
    dn = 1'b1;
    exp_q.push_back(ev_t'{cyc: m + 2, code: 3'd2});
`ifdef PAD_AUTOREPEAT_EN
    exp_q.push_back(ev_t'{cyc: m + 10, code: 3'd2});
    exp_q.push_back(ev_t'{cyc: m + 14, code: 3'd2});
`endif
    exp_q.push_back(ev_t'{cyc: m + 16, code: 3'd1});
`ifdef PAD_AUTOREPEAT_EN
    exp_q.push_back(ev_t'{cyc: m + 24, code: 3'd1});
`endif
    for (int t = 1; t <= 28; t++) begin
      step(1);
      dn = (t <= 24);
      up = (t >= 14 && t <= 24);
      @(negedge clk);
      if (t == 15) begin
        n_chk++;
        if (ract !== 1'b0) begin
          n_fail++;
          $display("FAIL owner_restart: got ract %b want 0", ract);
        end
      end
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL owner_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i])
      if (i < obs_q.size()) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL owner_cmd[%0d]: got cyc %0d code %0d want cyc %0d code %0d",
                   i, obs_q[i].cyc, obs_q[i].code, exp_q[i].cyc, exp_q[i].code);
        end
      end
  endtask

  task automatic test_rst_mid;
    step(1);
    exp_q.delete();
    obs_q.delete();
    ready = 1'b0;
    a = 1'b1;
    c = 1'b1;
    step(1);
    a = 1'b0;
    c = 1'b0;
    step(1);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b1 || code !== 3'd5) begin
      n_fail++;
      $display("FAIL rst_pre: got v=%b c=%0d want v=1 c=5", valid, code);
    end
    step(1);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b0 || code !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b c=%0d want v=0 c=0", valid, code);
    end
    step(1);
    rst = 1'b0;
    ready = 1'b1;
    step(5);
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_pending: got %0d cmds want 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_simul();
    test_stall();
    test_repeat();
    test_owner();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
